// File: rtl/ship_count_selector.sv
`default_nettype none
// ============================================================================
// Module   : ship_count_selector
// Purpose  : Ship-count decision phase: bounded inc/dec selection with confirm
//            and optional inactivity auto-confirm.
// Revision : 1.0 - initial release
// ============================================================================
module ship_count_selector #(
    parameter int CNT_W          = 3,
    parameter int MIN_SHIPS      = 1,
    parameter int MAX_SHIPS      = 5,
    parameter int DEFAULT_SHIPS  = 1,
    parameter int TIMEOUT_CYCLES = 500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             btn_inc,
    input  logic             btn_dec,
    input  logic             btn_confirm,
    output logic [CNT_W-1:0] amount_ships,
    output logic             selecting,
    output logic             ships_decided,
    output logic             timed_out
);

    localparam int             c_TMR_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit             c_TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_MIN  = CNT_W'(MIN_SHIPS);
    localparam logic [CNT_W-1:0]   c_MAX  = CNT_W'(MAX_SHIPS);
    localparam logic [CNT_W-1:0]   c_DEF  = CNT_W'(DEFAULT_SHIPS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SELECT  = 2'd1,
        S_DECIDED = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_amount, w_amount_nxt;
    logic [c_TMR_W-1:0] r_timer, w_timer_nxt;
    logic               r_timed_out, w_timed_out_nxt;
    logic               r_prev_inc, r_prev_dec, r_prev_conf;

    logic w_ev_inc, w_ev_dec, w_ev_conf;

    assign w_ev_inc  = btn_inc     & ~r_prev_inc;
    assign w_ev_dec  = btn_dec     & ~r_prev_dec;
    assign w_ev_conf = btn_confirm & ~r_prev_conf;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_amount    <= c_DEF;
            r_timer     <= '0;
            r_timed_out <= 1'b0;
            // Held-high assumption keeps buttons pressed through reset from firing
            r_prev_inc  <= 1'b1;
            r_prev_dec  <= 1'b1;
            r_prev_conf <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_amount    <= w_amount_nxt;
            r_timer     <= w_timer_nxt;
            r_timed_out <= w_timed_out_nxt;
            r_prev_inc  <= btn_inc;
            r_prev_dec  <= btn_dec;
            r_prev_conf <= btn_confirm;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_amount_nxt    = r_amount;
        w_timer_nxt     = r_timer;
        w_timed_out_nxt = r_timed_out;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt     = S_SELECT;
                    w_amount_nxt    = c_DEF;
                    w_timer_nxt     = '0;
                    w_timed_out_nxt = 1'b0;
                end
            end
            S_SELECT: begin
                if (w_ev_conf) begin
                    w_state_nxt     = S_DECIDED;
                    w_timed_out_nxt = 1'b0;
                end else if (w_ev_inc && w_ev_dec) begin
                    w_timer_nxt = '0;
                end else if (w_ev_inc) begin
                    if (r_amount < c_MAX)
                        w_amount_nxt = r_amount + CNT_W'(1);
                    w_timer_nxt = '0;
                end else if (w_ev_dec) begin
                    if (r_amount > c_MIN)
                        w_amount_nxt = r_amount - CNT_W'(1);
                    w_timer_nxt = '0;
                end else if (c_TO_EN && (r_timer == c_TMR_LAST)) begin
                    w_state_nxt     = S_DECIDED;
                    w_timed_out_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + c_TMR_W'(1);
                end
            end
            S_DECIDED: begin
                if (clear) begin
                    w_state_nxt     = S_IDLE;
                    w_amount_nxt    = c_DEF;
                    w_timed_out_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_amount_nxt    = c_DEF;
                w_timed_out_nxt = 1'b0;
            end
        endcase
    end

    assign amount_ships  = r_amount;
    assign selecting     = (r_state == S_SELECT);
    assign ships_decided = (r_state == S_DECIDED);
    assign timed_out     = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_ship_count_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ship_count_selector
// Purpose  : Directed self-checking bench; default-bounds instance with a
//            16-cycle timeout plus a wide-bounds instance with no timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ship_count_selector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst = 1'b0, a_start = 1'b0, a_clear = 1'b0;
    logic       a_inc = 1'b0, a_dec = 1'b0, a_conf = 1'b0;
    logic [2:0] a_amount;
    logic       a_sel, a_dec_out, a_to;

    logic       b_rst = 1'b0, b_start = 1'b0, b_clear = 1'b0;
    logic       b_inc = 1'b0, b_dec = 1'b0, b_conf = 1'b0;
    logic [3:0] b_amount;
    logic       b_sel, b_dec_out, b_to;

    int checks   = 0;
    int failures = 0;

    ship_count_selector #(
        .CNT_W(3), .MIN_SHIPS(1), .MAX_SHIPS(5), .DEFAULT_SHIPS(1), .TIMEOUT_CYCLES(16)
    ) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .clear(a_clear),
        .btn_inc(a_inc), .btn_dec(a_dec), .btn_confirm(a_conf),
        .amount_ships(a_amount), .selecting(a_sel),
        .ships_decided(a_dec_out), .timed_out(a_to)
    );

    ship_count_selector #(
        .CNT_W(4), .MIN_SHIPS(2), .MAX_SHIPS(10), .DEFAULT_SHIPS(3), .TIMEOUT_CYCLES(0)
    ) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .clear(b_clear),
        .btn_inc(b_inc), .btn_dec(b_dec), .btn_confirm(b_conf),
        .amount_ships(b_amount), .selecting(b_sel),
        .ships_decided(b_dec_out), .timed_out(b_to)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // which: 0=inc 1=dec 2=confirm; each press is one high cycle then one low cycle
    task automatic press_a(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            a_inc = (which == 0); a_dec = (which == 1); a_conf = (which == 2);
            tick();
            a_inc = 1'b0; a_dec = 1'b0; a_conf = 1'b0;
            tick();
        end
    endtask

    task automatic press_b(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            b_inc = (which == 0); b_dec = (which == 1); b_conf = (which == 2);
            tick();
            b_inc = 1'b0; b_dec = 1'b0; b_conf = 1'b0;
            tick();
        end
    endtask

    initial begin
        // Reset with inc held, then start while still held
        a_inc = 1'b1;
        tick(2);
        chk("a_rst_amount", 32'(a_amount), 1);
        chk("a_rst_sel", 32'(a_sel), 0);
        chk("a_rst_decided", 32'(a_dec_out), 0);
        chk("a_rst_to", 32'(a_to), 0);
        a_rst = 1'b1; a_start = 1'b1;
        tick();
        chk("a_start_sel", 32'(a_sel), 1);
        chk("a_held_no_inc", 32'(a_amount), 1);
        a_start = 1'b0; a_inc = 1'b0;
        tick();
        chk("a_held_release", 32'(a_amount), 1);
        press_a(0, 3);
        chk("a_inc3", 32'(a_amount), 4);

        // Saturation
        press_a(0, 6);
        chk("a_sat_max", 32'(a_amount), 5);
        press_a(1, 8);
        chk("a_sat_min", 32'(a_amount), 1);

        // Simultaneous inc+dec, then confirm+inc
        press_a(0, 2);
        a_inc = 1'b1; a_dec = 1'b1;
        tick();
        chk("a_incdec_same", 32'(a_amount), 3);
        a_inc = 1'b0; a_dec = 1'b0;
        tick();
        a_conf = 1'b1; a_inc = 1'b1;
        tick();
        chk("a_conf_decided", 32'(a_dec_out), 1);
        chk("a_conf_sel", 32'(a_sel), 0);
        chk("a_conf_amount", 32'(a_amount), 3);
        chk("a_conf_to", 32'(a_to), 0);
        a_conf = 1'b0; a_inc = 1'b0;
        tick();

        // Buttons ignored in DECIDED, then clear
        press_a(0, 1); press_a(1, 2); press_a(2, 1);
        chk("a_decided_hold", 32'(a_amount), 3);
        chk("a_decided_level", 32'(a_dec_out), 1);
        a_clear = 1'b1;
        tick();
        chk("a_clear_decided", 32'(a_dec_out), 0);
        chk("a_clear_amount", 32'(a_amount), 1);
        chk("a_clear_sel", 32'(a_sel), 0);
        a_clear = 1'b0;
        press_a(0, 1);
        chk("a_idle_ignore", 32'(a_amount), 1);

        // start+clear together in IDLE; timeout 16 cycles after entry
        a_start = 1'b1; a_clear = 1'b1;
        tick();
        chk("a_startclear_sel", 32'(a_sel), 1);
        a_start = 1'b0; a_clear = 1'b0;
        tick(15);
        chk("a_to_early", 32'(a_sel), 1);
        tick();
        chk("a_to_decided", 32'(a_dec_out), 1);
        chk("a_to_flag", 32'(a_to), 1);
        chk("a_to_amount", 32'(a_amount), 1);

        // Timeout 16 cycles after last press at count 2
        a_clear = 1'b1; tick(); a_clear = 1'b0;
        chk("a_clear_to", 32'(a_to), 0);
        a_start = 1'b1; tick(); a_start = 1'b0;
        a_inc = 1'b1; tick(); a_inc = 1'b0;
        tick(15);
        chk("a_to2_early", 32'(a_sel), 1);
        tick();
        chk("a_to2_flag", 32'(a_to), 1);
        chk("a_to2_amount", 32'(a_amount), 2);

        // Press at cycle 10 restarts the timer
        a_clear = 1'b1; tick(); a_clear = 1'b0;
        a_start = 1'b1; tick(); a_start = 1'b0;
        a_inc = 1'b1; tick(); a_inc = 1'b0;
        tick(8);
        a_inc = 1'b1; tick(); a_inc = 1'b0;
        tick(15);
        chk("a_to3_early", 32'(a_sel), 1);
        chk("a_to3_amt_mid", 32'(a_amount), 3);
        tick();
        chk("a_to3_decided", 32'(a_dec_out), 1);
        chk("a_to3_flag", 32'(a_to), 1);
        chk("a_to3_amount", 32'(a_amount), 3);

        // Confirm on the timeout cycle wins
        a_clear = 1'b1; tick(); a_clear = 1'b0;
        a_start = 1'b1; tick(); a_start = 1'b0;
        tick(15);
        a_conf = 1'b1; tick(); a_conf = 1'b0;
        chk("a_conf_vs_to_dec", 32'(a_dec_out), 1);
        chk("a_conf_vs_to_flag", 32'(a_to), 0);

        // Mid-operation reset
        a_clear = 1'b1; tick(); a_clear = 1'b0;
        a_start = 1'b1; tick(); a_start = 1'b0;
        press_a(0, 3);
        chk("a_mid_amt", 32'(a_amount), 4);
        a_rst = 1'b0; tick();
        chk("a_mid_rst_sel", 32'(a_sel), 0);
        chk("a_mid_rst_amount", 32'(a_amount), 1);
        a_rst = 1'b1; tick();

        // Second parameter set: bounds 2..10, default 3, no timeout
        tick();
        chk("b_rst_amount", 32'(b_amount), 3);
        chk("b_rst_sel", 32'(b_sel), 0);
        b_rst = 1'b1; b_start = 1'b1; tick(); b_start = 1'b0;
        chk("b_start_sel", 32'(b_sel), 1);
        chk("b_start_amount", 32'(b_amount), 3);
        press_b(0, 10);
        chk("b_sat_max", 32'(b_amount), 10);
        press_b(1, 12);
        chk("b_sat_min", 32'(b_amount), 2);
        tick(40);
        chk("b_no_timeout", 32'(b_sel), 1);
        chk("b_no_timeout_dec", 32'(b_dec_out), 0);
        b_conf = 1'b1; tick(); b_conf = 1'b0;
        chk("b_conf_decided", 32'(b_dec_out), 1);
        chk("b_conf_amount", 32'(b_amount), 2);
        chk("b_conf_to", 32'(b_to), 0);
        b_clear = 1'b1; tick(); b_clear = 1'b0;
        chk("b_clear_amount", 32'(b_amount), 3);
        chk("b_clear_decided", 32'(b_dec_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
